stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch datapath. Converts debounced push-button levels into start/pause, lap-hold and clear commands. Generates the 1 Hz count-enable pulse from the 50 MHz clock and drives the BCD time counter's enable, direction and clear inputs. Sits between the key debouncers and the time counter / 7-segment display path, replacing the free-running prescaler tap.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick (>=2); prescaler width is $clog2(TICK_DIV)
ALARM_TICKS, 5, number of ticks alarm stays high after a countdown reaches zero (>=1)

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
btn_start  input  1  debounced start/pause level, active-high
btn_lap  input  1  debounced lap level, active-high
btn_clear  input  1  debounced clear level, active-high
dir_sel  input  1  1 = count up, 0 = count down; sampled only on start from IDLE
at_zero  input  1  counter value is 00:00:00 (combinational from counter)
cnt_en  output  1  one-cycle count-enable pulse to time counter
cnt_up  output  1  counting direction to time counter
cnt_clr  output  1  one-cycle synchronous clear pulse to time counter
hold  output  1  display freeze (lap) to display latch
alarm  output  1  countdown-finished indicator
state_o  output  2  current FSM state, for debug LEDs

Behaviour:
- Reset, on a clk edge with reset=1: state IDLE, prescaler 0, alarm counter 0, edge registers 0. Outputs: cnt_en=0, cnt_clr=0, hold=0, alarm=0, cnt_up=1. Reset takes effect mid-operation in any state.
- Edge detect: rise_x = btn_x & ~btn_x_q, where btn_x_q is registered. A held button produces exactly one rise.
- Priority per cycle: clear > start > lap. Only the highest-priority rise is acted on; lower ones are dropped, not queued.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3 (2-bit, encoded as state_o).
- IDLE, rise_start:
  - cnt_up <= dir_sel.
  - If dir_sel=0 and at_zero=1: start is refused and the block stays IDLE.
  - Otherwise go to RUN; prescaler keeps its value (0 after a clear).
- RUN:
  - Prescaler increments every cycle. At TICK_DIV-1 it wraps to 0, and cnt_en=1 on the next cycle for exactly one cycle. Tick period is exactly TICK_DIV cycles.
  - rise_start -> PAUSE.
  - rise_lap toggles hold.
  - rise_clear is ignored.
- RUN, down mode: if cnt_up=0 and at_zero=1 -> DONE. This check beats rise_start in the same cycle. No further cnt_en is issued; prescaler <= 0, alarm <= 1.
- PAUSE:
  - Prescaler frozen, so a fractional second is preserved on resume; cnt_en=0.
  - rise_start -> RUN.
  - rise_lap clears hold (no set).
  - rise_clear -> IDLE with cnt_clr=1 for one cycle, prescaler 0, hold 0.
- DONE:
  - Prescaler runs; each wrap decrements the alarm counter, which is loaded with ALARM_TICKS on entry. alarm falls when the counter reaches 0 and stays low.
  - rise_start and rise_lap are ignored.
  - rise_clear -> IDLE, cnt_clr pulse, alarm 0, hold 0.
- IDLE: rise_clear issues a cnt_clr pulse and zeroes the prescaler; rise_lap is ignored.
- Up mode: wrap of the counter from its maximum to 0 is the counter's job; the controller keeps running.
- All outputs are registered; there is no combinational input-to-output path.
- cnt_up changes only on the IDLE->RUN transition.

Decomposition:
- stopwatch_pkg holds:
  - the typedef enum logic [1:0] sw_state_t {SW_IDLE, SW_RUN, SW_PAUSE, SW_DONE}
  - localparam TICK_DIV_50MHZ = 50000000
  - localparam ALARM_TICKS_DEF = 5
- Sub-module rise_detect: one-bit registered rising-edge pulse, synchronous reset. Instantiated three times.
- Prescaler and alarm counter stay inline.

Test Plan:
- Basic up count (TICK_DIV=4, dir_sel=1): rise_start -> state RUN; cnt_en pulses every 4 cycles, the first 4 cycles after entry; after 12 cycles, 3 pulses; cnt_up=1.
- Pause/resume: pause 2 cycles after a tick -> no cnt_en for 20 cycles in PAUSE. Resume -> first cnt_en after 2 more cycles (prescaler preserved).
- Lap and clear: in RUN, lap -> hold=1; lap again -> hold=0. Lap, then pause, then lap -> hold=0. Clear in RUN -> ignored. Clear in PAUSE -> cnt_clr high for exactly 1 cycle, state IDLE.
- Countdown finish (TICK_DIV=4, ALARM_TICKS=2, dir_sel=0, at_zero=0): start -> cnt_up=0. Drive at_zero=1 -> DONE next cycle, alarm=1 for 8 cycles then 0. Start ignored; clear -> IDLE, cnt_clr pulse, alarm 0.
- Refused start: dir_sel=0, at_zero=1 in IDLE, rise_start -> state stays IDLE, cnt_en never asserts.
- Simultaneous and reset:
  - start+lap+clear rising together in PAUSE -> only the clear is acted on.
  - Holding btn_start high for 100 cycles -> a single pause/resume toggle.
  - reset asserted mid-RUN with hold=1 -> next cycle all outputs at reset values, cnt_up=1, state IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch sequencing controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      SW_IDLE  = 2'd0,
      SW_RUN   = 2'd1,
      SW_PAUSE = 2'd2,
      SW_DONE  = 2'd3
   } sw_state_t;

   localparam int TICK_DIV_50MHZ  = 50000000;
   localparam int ALARM_TICKS_DEF = 5;

endpackage

// File: rtl/stopwatch_ctrl_rise.sv
// One-bit rising-edge detector: pulses for the first cycle a level is seen high.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_lvl,
   output logic o_rise
);

   logic r_lvl_q;

   // Remember last cycle's level so a held button yields a single pulse.
   always_ff @(posedge clk) begin
      if (reset) r_lvl_q <= 1'b0;
      else       r_lvl_q <= i_lvl;
   end

   assign o_rise = i_lvl & ~r_lvl_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns button edges into run/pause/lap/clear
// commands, divides clk down to the count tick and times the countdown alarm.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_50MHZ,
   parameter int ALARM_TICKS = ALARM_TICKS_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clear,
   input  logic       dir_sel,
   input  logic       at_zero,
   output logic       cnt_en,
   output logic       cnt_up,
   output logic       cnt_clr,
   output logic       hold,
   output logic       alarm,
   output logic [1:0] state_o
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = $clog2(ALARM_TICKS + 1);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] A_LOAD = AW'(ALARM_TICKS);

   sw_state_t     r_state, w_state_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt, w_presc_inc;
   logic [AW-1:0] r_acnt,  w_acnt_nxt;
   logic          r_cnt_en, r_cnt_up, r_cnt_clr, r_hold, r_alarm;
   logic          w_cnt_en_nxt, w_cnt_up_nxt, w_cnt_clr_nxt, w_hold_nxt, w_alarm_nxt;
   logic          w_rise_start, w_rise_lap, w_rise_clear;
   logic          w_do_start, w_do_lap, w_do_clear, w_wrap;

   rise_detect u_rise_start (.clk(clk), .reset(reset), .i_lvl(btn_start), .o_rise(w_rise_start));
   rise_detect u_rise_lap   (.clk(clk), .reset(reset), .i_lvl(btn_lap),   .o_rise(w_rise_lap));
   rise_detect u_rise_clear (.clk(clk), .reset(reset), .i_lvl(btn_clear), .o_rise(w_rise_clear));

   // Priority is resolved before looking at the state: a higher-priority
   // rise swallows lower ones even where that state then ignores it.
   assign w_do_clear = w_rise_clear;
   assign w_do_start = w_rise_start & ~w_rise_clear;
   assign w_do_lap   = w_rise_lap & ~w_rise_start & ~w_rise_clear;

   assign w_wrap      = (r_presc == P_LAST);
   assign w_presc_inc = w_wrap ? '0 : r_presc + PW'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= SW_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      w_state_nxt   = r_state;
      w_presc_nxt   = r_presc;
      w_acnt_nxt    = r_acnt;
      w_cnt_en_nxt  = 1'b0;
      w_cnt_clr_nxt = 1'b0;
      w_cnt_up_nxt  = r_cnt_up;
      w_hold_nxt    = r_hold;
      w_alarm_nxt   = r_alarm;
      case (r_state)
         SW_IDLE: begin
            if (w_do_clear) begin
               w_cnt_clr_nxt = 1'b1;
               w_presc_nxt   = '0;
            end else if (w_do_start && !(!dir_sel && at_zero)) begin
               // Direction is latched only when a run actually begins.
               w_state_nxt  = SW_RUN;
               w_cnt_up_nxt = dir_sel;
            end
         end
         SW_RUN: begin
            if (!r_cnt_up && at_zero) begin
               // Countdown finished: beats any button this cycle.
               w_state_nxt = SW_DONE;
               w_presc_nxt = '0;
               w_alarm_nxt = 1'b1;
               w_acnt_nxt  = A_LOAD;
            end else begin
               w_presc_nxt  = w_presc_inc;
               w_cnt_en_nxt = w_wrap;
               if (w_do_start)    w_state_nxt = SW_PAUSE;
               else if (w_do_lap) w_hold_nxt  = ~r_hold;
            end
         end
         SW_PAUSE: begin
            if (w_do_clear) begin
               w_state_nxt   = SW_IDLE;
               w_cnt_clr_nxt = 1'b1;
               w_presc_nxt   = '0;
               w_hold_nxt    = 1'b0;
            end else if (w_do_start) begin
               w_state_nxt = SW_RUN;
            end else if (w_do_lap) begin
               w_hold_nxt = 1'b0;
            end
         end
         SW_DONE: begin
            if (w_do_clear) begin
               w_state_nxt   = SW_IDLE;
               w_cnt_clr_nxt = 1'b1;
               w_presc_nxt   = '0;
               w_acnt_nxt    = '0;
               w_alarm_nxt   = 1'b0;
               w_hold_nxt    = 1'b0;
            end else begin
               w_presc_nxt = w_presc_inc;
               if (w_wrap && r_acnt != '0) begin
                  w_acnt_nxt = r_acnt - AW'(1);
                  if (r_acnt == AW'(1)) w_alarm_nxt = 1'b0;
               end
            end
         end
         default: w_state_nxt = SW_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc   <= '0;
         r_acnt    <= '0;
         r_cnt_en  <= 1'b0;
         r_cnt_clr <= 1'b0;
         r_cnt_up  <= 1'b1;
         r_hold    <= 1'b0;
         r_alarm   <= 1'b0;
      end else begin
         r_presc   <= w_presc_nxt;
         r_acnt    <= w_acnt_nxt;
         r_cnt_en  <= w_cnt_en_nxt;
         r_cnt_clr <= w_cnt_clr_nxt;
         r_cnt_up  <= w_cnt_up_nxt;
         r_hold    <= w_hold_nxt;
         r_alarm   <= w_alarm_nxt;
      end
   end

   assign cnt_en  = r_cnt_en;
   assign cnt_clr = r_cnt_clr;
   assign cnt_up  = r_cnt_up;
   assign hold    = r_hold;
   assign alarm   = r_alarm;
   assign state_o = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle tick and 2-tick alarm.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       reset, btn_start, btn_lap, btn_clear, dir_sel, at_zero;
   logic       cnt_en, cnt_up, cnt_clr, hold, alarm;
   logic [1:0] state_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_en, first_en;

   stopwatch_ctrl #(.TICK_DIV(4), .ALARM_TICKS(2)) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
      .btn_clear(btn_clear), .dir_sel(dir_sel), .at_zero(at_zero),
      .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr), .hold(hold),
      .alarm(alarm), .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
      dir_sel = 1'b1; at_zero = 1'b0;
      step(2);
      reset = 1'b0;
      chk("rst_state", state_o, 0);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_cnt_clr", cnt_clr, 0);
      chk("rst_hold", hold, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_cnt_up", cnt_up, 1);

      // basic up count
      btn_start = 1'b1; step(1);
      chk("up_state_run", state_o, 1);
      chk("up_cnt_up", cnt_up, 1);
      btn_start = 1'b0;
      n_en = 0; first_en = 0;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (cnt_en) begin
            n_en++;
            if (first_en == 0) first_en = k;
         end
      end
      chk("up_first_tick", first_en, 4);
      chk("up_tick_count", n_en, 3);

      // pause two cycles after a tick, then resume
      step(1);
      btn_start = 1'b1; step(1);
      chk("pause_state", state_o, 2);
      btn_start = 1'b0;
      n_en = 0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         n_en += int'(cnt_en);
      end
      chk("pause_no_tick", n_en, 0);
      btn_start = 1'b1; step(1);
      chk("resume_state", state_o, 1);
      btn_start = 1'b0; step(1);
      chk("resume_no_tick_yet", cnt_en, 0);
      step(1);
      chk("resume_tick", cnt_en, 1);

      // lap and clear
      btn_lap = 1'b1; step(1);
      chk("lap_set", hold, 1);
      btn_lap = 1'b0; step(1);
      btn_lap = 1'b1; step(1);
      chk("lap_toggle_off", hold, 0);
      btn_lap = 1'b0; step(1);
      btn_lap = 1'b1; step(1);
      btn_lap = 1'b0; step(1);
      btn_start = 1'b1; step(1);
      chk("lap_pause_state", state_o, 2);
      chk("lap_pause_hold", hold, 1);
      btn_start = 1'b0; step(1);
      btn_lap = 1'b1; step(1);
      chk("lap_in_pause_clears", hold, 0);
      btn_lap = 1'b0; step(1);
      btn_start = 1'b1; step(1);
      btn_start = 1'b0; step(1);
      btn_clear = 1'b1; step(1);
      chk("clr_run_state", state_o, 1);
      chk("clr_run_no_pulse", cnt_clr, 0);
      btn_clear = 1'b0; step(1);
      btn_start = 1'b1; step(1);
      btn_start = 1'b0; step(1);
      btn_clear = 1'b1; step(1);
      chk("clr_pause_pulse", cnt_clr, 1);
      chk("clr_pause_state", state_o, 0);
      btn_clear = 1'b0; step(1);
      chk("clr_pulse_one_cycle", cnt_clr, 0);

      // countdown finish
      dir_sel = 1'b0; at_zero = 1'b0;
      btn_start = 1'b1; step(1);
      chk("dn_state_run", state_o, 1);
      chk("dn_cnt_up", cnt_up, 0);
      btn_start = 1'b0; step(3);
      at_zero = 1'b1; step(1);
      chk("dn_done_state", state_o, 3);
      chk("dn_alarm_on", alarm, 1);
      n_en = 0;
      for (int k = 0; k < 7; k++) begin
         step(1);
         n_en += int'(cnt_en);
      end
      chk("dn_alarm_still_on", alarm, 1);
      chk("dn_no_tick_in_done", n_en, 0);
      step(1);
      chk("dn_alarm_off", alarm, 0);
      btn_start = 1'b1; step(1);
      chk("dn_start_ignored", state_o, 3);
      btn_start = 1'b0; step(1);
      btn_clear = 1'b1; step(1);
      chk("dn_clr_state", state_o, 0);
      chk("dn_clr_pulse", cnt_clr, 1);
      chk("dn_clr_alarm", alarm, 0);
      btn_clear = 1'b0; step(1);

      // refused start: counting down from zero
      btn_start = 1'b1; step(1);
      chk("refuse_state", state_o, 0);
      btn_start = 1'b0;
      n_en = 0;
      for (int k = 0; k < 8; k++) begin
         step(1);
         n_en += int'(cnt_en);
      end
      chk("refuse_no_tick", n_en, 0);
      chk("refuse_state_after", state_o, 0);

      // simultaneous rises in PAUSE: clear wins
      dir_sel = 1'b1; at_zero = 1'b0;
      btn_start = 1'b1; step(1);
      btn_start = 1'b0; step(1);
      btn_lap = 1'b1; step(1);
      btn_lap = 1'b0; step(1);
      btn_start = 1'b1; step(1);
      chk("sim_pause_state", state_o, 2);
      chk("sim_pause_hold", hold, 1);
      btn_start = 1'b0; step(1);
      btn_start = 1'b1; btn_lap = 1'b1; btn_clear = 1'b1; step(1);
      chk("sim_state_idle", state_o, 0);
      chk("sim_clr_pulse", cnt_clr, 1);
      btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; step(1);

      // long start press toggles once
      btn_start = 1'b1; step(1);
      btn_start = 1'b0; step(1);
      btn_start = 1'b1; step(100);
      chk("held_start_state", state_o, 2);
      btn_start = 1'b0; step(1);
      chk("held_release_state", state_o, 2);

      // reset in the middle of a down run with hold set
      btn_clear = 1'b1; step(1);
      btn_clear = 1'b0; step(1);
      dir_sel = 1'b0;
      btn_start = 1'b1; step(1);
      btn_start = 1'b0; step(1);
      btn_lap = 1'b1; step(1);
      btn_lap = 1'b0; step(1);
      chk("pre_rst_state", state_o, 1);
      chk("pre_rst_hold", hold, 1);
      chk("pre_rst_cnt_up", cnt_up, 0);
      reset = 1'b1; step(1);
      chk("mid_rst_state", state_o, 0);
      chk("mid_rst_hold", hold, 0);
      chk("mid_rst_cnt_up", cnt_up, 1);
      chk("mid_rst_cnt_en", cnt_en, 0);
      chk("mid_rst_cnt_clr", cnt_clr, 0);
      chk("mid_rst_alarm", alarm, 0);
      reset = 1'b0; step(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
